serial_adder: RTL and testbench

Bit-serial N-bit adder that adds one bit per clock cycle through a single full-adder cell and a registered carry. It is the addition counterpart of the team's subtractor cells and trades latency for area. It accepts operands on a start strobe, processes bits LSB-first, and reports the result with a one-cycle done pulse. The registered sum and carry-out hold until the next operation completes.

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Operands are captured on an accepted start; sum/cout update only when the last bit completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_count;

    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_ha2_s;
    logic             w_ha2_c;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Full adder as two half adders; the second half adder folds in the carry flop.
    assign w_ha1_s    = r_a_sr[0] ^ r_b_sr[0];
    assign w_ha1_c    = r_a_sr[0] & r_b_sr[0];
    assign w_ha2_s    = w_ha1_s ^ r_carry;
    assign w_ha2_c    = w_ha1_s & r_carry;
    assign w_co       = w_ha1_c | w_ha2_c;
    assign w_sum_next = {w_ha2_s, r_sum_sr[WIDTH-1:1]};
    assign w_last     = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_sum_sr <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_co;
                    r_count  <= r_count + CW'(1);
                    // Last bit: publish the result directly from the next shift value.
                    if (w_last) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/control cases and
// a 4-bit instance swept over every operand and carry-in combination.
module tb_serial_adder;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          dbg_state;

    logic          start4;
    logic [W4-1:0] a4;
    logic [W4-1:0] b4;
    logic          cin4;
    logic          busy4;
    logic          done4;
    logic [W4-1:0] sum4;
    logic          cout4;
    logic          dbg_state4;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .dbg_state(dbg_state)
    );

    serial_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .dbg_state(dbg_state4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; optionally pulses start with junk operands mid-run.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es, input logic ec,
                          input logic [W-1:0] ps, input logic pc, input bit mid);
        int n_busy = 0;
        int n_done = 0;
        int done_k = -1;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
        for (int k = 0; k <= W + 2; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin n_done++; done_k = k; end
            if (k == 0) check({tag, "_state_run"}, 32'(dbg_state), 32'd1);
            if (k == W - 1) begin
                check({tag, "_hold_sum"},  32'(sum),  32'(ps));
                check({tag, "_hold_cout"}, 32'(cout), 32'(pc));
            end
            if (k == W) begin
                check({tag, "_sum"},  32'(sum),  32'(es));
                check({tag, "_cout"}, 32'(cout), 32'(ec));
            end
            if (mid && k == 3) begin start = 1'b1; a = 8'hAA; end
            if (mid && k == 4) start = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(W));
        check({tag, "_done_count"},  32'(n_done), 32'd1);
        check({tag, "_done_cycle"},  32'(done_k), 32'(W));
    endtask

    initial begin
        int n_done;
        int t;
        logic [4:0] exp5;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_sum",   32'(sum),       32'd0);
        check("rst_cout",  32'(cout),      32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_sum4",  32'(sum4),      32'd0);
        rst = 1'b0;

        run_op("t3c5a",  8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("tff01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0);
        run_op("tffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("tmid",   8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'hFF, 1'b1, 1'b1);

        // Abort in the 4th RUN cycle.
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_done",  32'(done),      32'd0);
        check("abort_sum",   32'(sum),       32'd0);
        check("abort_cout",  32'(cout),      32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op("post_rst", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back with start held high: done every W+1 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(posedge clk);
        #1;
        n_done = 0;
        for (int k = 0; k < 3 * (W + 1); k++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_done_cycle", 32'(k), 32'(W + n_done * (W + 1)));
                check("b2b_sum",  32'(sum),  32'h02);
                check("b2b_cout", 32'(cout), 32'd0);
                n_done++;
            end
        end
        check("b2b_done_count", 32'(n_done), 32'd3);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Exhaustive 4-bit sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic);
                    @(posedge clk);
                    #1;
                    start4 = 1'b0; a4 = ~a4; b4 = ~b4;
                    t = 0;
                    do begin
                        @(negedge clk);
                        t++;
                    end while (!done4 && t < 20);
                    exp5 = 5'(ia) + 5'(ib) + 5'(ic);
                    check("w4_done",    32'(done4), 32'd1);
                    check("w4_latency", 32'(t),     32'(W4 + 1));
                    check("w4_sum",     32'(sum4),  32'(exp5[3:0]));
                    check("w4_cout",    32'(cout4), 32'(exp5[4]));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
